// File: rtl/pc_apparatus_pkg.sv
// Shared definitions for the fetch-stage program counter.
// Holds the next-PC select encodings used by pc_next_mux and its drivers.
package pc_apparatus_pkg;

    localparam int unsigned PCSEL_W = 2;

    // Next-PC source select; the reserved code behaves like sequential fetch.
    typedef enum logic [PCSEL_W-1:0] {
        PCSEL_PCPLUSFOUR = 2'b00,
        PCSEL_PCOFFSET   = 2'b01,
        PCSEL_REGOFFSET  = 2'b10,
        PCSEL_RESERVED   = 2'b11
    } pcsel_e;

endpackage

// File: rtl/pc_apparatus_next_mux.sv
// pc_next_mux: combinational next-PC selection.
// Ports:
//   pc     - current PC
//   cmp    - branch condition (1 = taken); only consulted for PCOFFSET
//   imm    - sign-extended word offset, scaled by 4 here
//   pcSel  - next-PC source select (pcsel_e encoding)
//   reg1   - base register for register-relative jumps
//   nextPc - selected next PC
module pc_next_mux
    import pc_apparatus_pkg::*;
#(
    parameter int unsigned DBITS = 32
) (
    input  logic [DBITS-1:0]   pc,
    input  logic               cmp,
    input  logic [DBITS-1:0]   imm,
    input  logic [PCSEL_W-1:0] pcSel,
    input  logic [DBITS-1:0]   reg1,
    output logic [DBITS-1:0]   nextPc
);

    logic [DBITS-1:0] pcPlus4;
    logic [DBITS-1:0] immOff;

    // Word offset to byte offset; bits shifted past the top are dropped.
    assign pcPlus4 = pc + DBITS'(4);
    assign immOff  = {imm[DBITS-3:0], 2'b00};

    // cmp is only looked at inside the PCOFFSET arm so an unknown cmp
    // cannot leak into the other selections.
    always_comb begin
        nextPc = pcPlus4;
        case (pcsel_e'(pcSel))
            PCSEL_PCOFFSET: begin
                if (cmp == 1'b1) begin
                    nextPc = pcPlus4 + immOff;
                end
            end
            PCSEL_REGOFFSET: nextPc = reg1 + immOff;
            default:         nextPc = pcPlus4;
        endcase
    end

endmodule

// File: rtl/pc_apparatus.sv
// pc_apparatus: fetch-stage program-counter register.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset, loads START_PC
//   cmp    - branch condition from the comparator
//   imm    - sign-extended word offset
//   pcSel  - next-PC source select
//   reg1   - base register for register-relative jumps
//   pcOut  - current PC, straight from the register
module pc_apparatus
    import pc_apparatus_pkg::*;
#(
    parameter int unsigned     DBITS    = 32,
    parameter logic [DBITS-1:0] START_PC = DBITS'(64)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmp,
    input  logic [DBITS-1:0]   imm,
    input  logic [PCSEL_W-1:0] pcSel,
    input  logic [DBITS-1:0]   reg1,
    output logic [DBITS-1:0]   pcOut
);

    logic [DBITS-1:0] pc;
    logic [DBITS-1:0] nextPc;

    pc_next_mux #(
        .DBITS (DBITS)
    ) u_next_mux (
        .pc     (pc),
        .cmp    (cmp),
        .imm    (imm),
        .pcSel  (pcSel),
        .reg1   (reg1),
        .nextPc (nextPc)
    );

    // PC register; reset wins over the clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= START_PC;
        end else begin
            pc <= nextPc;
        end
    end

    assign pcOut = pc;

endmodule

// File: tb/tb_pc_apparatus.sv
module tb_pc_apparatus;

    logic        clk;
    logic        reset;
    logic        cmp;
    logic [31:0] imm;
    logic [1:0]  pcSel;
    logic [31:0] reg1;
    logic [31:0] pcOut;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_pc;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    localparam logic [1:0] SEL_P4  = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_REG = 2'b10;
    localparam logic [1:0] SEL_RSV = 2'b11;

    pc_apparatus dut (
        .clk   (clk),
        .reset (reset),
        .cmp   (cmp),
        .imm   (imm),
        .pcSel (pcSel),
        .reg1  (reg1),
        .pcOut (pcOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Reference next-PC behaviour.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] sel,
                                               input logic c, input logic [31:0] im,
                                               input logic [31:0] r1);
        logic [31:0] off;
        off = im * 32'd4;
        if (sel == SEL_REG) return r1 + off;
        if (sel == SEL_BR && c === 1'b1) return pc + 32'd4 + off;
        return pc + 32'd4;
    endfunction

    // Drive one cycle of inputs at the falling edge, queue the expectation,
    // then wait until just after the following rising edge.
    task automatic drive_edge(input logic [1:0] sel, input logic c, input logic [31:0] im,
                              input logic [31:0] r1);
        @(negedge clk);
        pcSel = sel;
        cmp   = c;
        imm   = im;
        reg1  = r1;
        model_pc = model_next(model_pc, sel, c, im, r1);
        exp_q.push_back(model_pc);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmp = 1'b0; imm = '0; pcSel = SEL_P4; reg1 = '0;
        model_pc = 32'h40;
        #1;
        checks++;
        if (pcOut !== 32'h40) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", pcOut, 32'h40);
        end
        @(posedge clk); #1;
        checks++;
        if (pcOut !== 32'h40) begin
            errors++;
            $display("FAIL reset_held: got %h expected %h", pcOut, 32'h40);
        end
    endtask

    task automatic test_sequential();
        @(negedge clk);
        reset = 1'b0;
        pcSel = SEL_P4;
        model_pc = model_next(model_pc, SEL_P4, 1'b0, '0, '0);
        exp_q.push_back(model_pc);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) drive_edge(SEL_P4, 1'b0, 32'h0, 32'h0);
            exp_v = exp_q.pop_front();
            checks++;
            if (pcOut !== exp_v) begin
                errors++;
                $display("FAIL sequential[%0d]: got %h expected %h", i, pcOut, exp_v);
            end
        end
    endtask

    task automatic test_branch();
        logic        tc[3];
        logic [31:0] ti[3];
        tc[0] = 1'b0; ti[0] = 32'h4;
        tc[1] = 1'b1; ti[1] = 32'h4;
        tc[2] = 1'b1; ti[2] = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            drive_edge(SEL_BR, tc[i], ti[i], 32'hDEAD_BEEF);
            exp_v = exp_q.pop_front();
            checks++;
            if (pcOut !== exp_v) begin
                errors++;
                $display("FAIL branch[%0d]: got %h expected %h", i, pcOut, exp_v);
            end
        end
    endtask

    task automatic test_regjump();
        logic [31:0] tr[3];
        logic [31:0] ti[3];
        tr[0] = 32'h100; ti[0] = 32'h0;
        tr[1] = 32'h103; ti[1] = 32'h1;
        tr[2] = 32'h50;  ti[2] = 32'h4;
        for (int i = 0; i < 3; i++) begin
            drive_edge(SEL_REG, 1'bx, ti[i], tr[i]);
            exp_v = exp_q.pop_front();
            checks++;
            if (pcOut !== exp_v) begin
                errors++;
                $display("FAIL regjump[%0d]: got %h expected %h", i, pcOut, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        pcSel = SEL_P4; cmp = 1'b0;
        #2;
        reset = 1'b1;
        model_pc = 32'h40;
        #1;
        checks++;
        if (pcOut !== 32'h40) begin
            errors++;
            $display("FAIL midrun_reset: got %h expected %h", pcOut, 32'h40);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (pcOut !== 32'h40) begin
                errors++;
                $display("FAIL midrun_reset_held[%0d]: got %h expected %h", i, pcOut, 32'h40);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        pcSel = SEL_RSV;
        cmp   = 1'b1;
        imm   = 32'h10;
        model_pc = model_next(model_pc, SEL_RSV, 1'b1, 32'h10, '0);
        exp_q.push_back(model_pc);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (pcOut !== exp_v) begin
            errors++;
            $display("FAIL reserved_sel: got %h expected %h", pcOut, exp_v);
        end
    endtask

    task automatic test_wrap();
        drive_edge(SEL_REG, 1'b0, 32'h0, 32'hFFFF_FFFC);
        drive_edge(SEL_P4, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (pcOut !== exp_v && i == 1) begin
                errors++;
                $display("FAIL wrap: got %h expected %h", pcOut, exp_v);
            end
        end
        checks++;
        if (pcOut !== 32'h0) begin
            errors++;
            $display("FAIL wrap_zero: got %h expected %h", pcOut, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  s;
        logic        c;
        logic [31:0] im;
        logic [31:0] r1;
        for (int i = 0; i < 40; i++) begin
            s  = 2'($urandom_range(0, 3));
            c  = 1'($urandom_range(0, 1));
            im = 32'($signed(7'($urandom_range(0, 127))));
            r1 = $urandom();
            drive_edge(s, c, im, r1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b2b_queue[%0d]: got empty expected entry", i);
            end else begin
                exp_v = exp_q.pop_front();
                checks++;
                if (pcOut !== exp_v) begin
                    errors++;
                    $display("FAIL b2b[%0d] sel=%0d cmp=%0d: got %h expected %h",
                             i, s, c, pcOut, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_regjump();
        test_async_reset();
        test_wrap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
